sdram_init_checker: RTL and testbench

- Passive, cycle-accurate checker on the SDRAM command bus; the receiving end of the SDRAM power-up initialization sequence.
- Decodes CKE/CS/RAS/CAS/WE/BA/ADDR every cycle and verifies the JEDEC order: power-up wait, PRECHARGE ALL, NUM_REF auto-refreshes, LOAD MODE REGISTER.
- Enforces inter-command gaps and captures the programmed mode register.
- Sits beside the SDRAM pins in simulation and on-chip debug; flags ready or the first violation.

---
 rtl/sdram_init_checker.sv | 221 ++++++++++++++++++++++
 tb/tb_sdram_init_checker.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_checker.sv
// rtl/sdram_init_checker.sv - passive checker for the SDRAM power-up initialization sequence
module sdram_init_checker #(
   parameter int PWRUP_CYC = 5000,
   parameter int TRP_CYC   = 2,
   parameter int TRFC_CYC  = 7,
   parameter int TMRD_CYC  = 2,
   parameter int NUM_REF   = 2
) (
   input  logic        iclk,
   input  logic        ireset,
   input  logic        DRAM_CKE,
   input  logic        DRAM_CS_N,
   input  logic        DRAM_RAS_N,
   input  logic        DRAM_CAS_N,
   input  logic        DRAM_WE_N,
   input  logic [1:0]  DRAM_BA,
   input  logic [12:0] DRAM_ADDR,
   output logic        oready,
   output logic        oerr,
   output logic [2:0]  oerr_code,
   output logic [12:0] omode_reg,
   output logic [3:0]  oref_cnt,
   output logic [3:0]  ostate
);

   localparam int PW_W    = $clog2(PWRUP_CYC + 2);
   localparam int GAP_MAX = (TRP_CYC > TRFC_CYC)
                            ? ((TRP_CYC > TMRD_CYC) ? TRP_CYC : TMRD_CYC)
                            : ((TRFC_CYC > TMRD_CYC) ? TRFC_CYC : TMRD_CYC);
   localparam int GAP_W   = $clog2(GAP_MAX + 2);

   localparam logic [2:0] ERR_EARLY  = 3'd1;
   localparam logic [2:0] ERR_SEQ    = 3'd2;
   localparam logic [2:0] ERR_TIMING = 3'd3;
   localparam logic [2:0] ERR_MODE   = 3'd4;
   localparam logic [2:0] ERR_CKE    = 3'd5;

   typedef enum logic [3:0] {
      S_WAIT_PWR = 4'd0,
      S_WAIT_PRE = 4'd1,
      S_GAP_PRE  = 4'd2,
      S_WAIT_REF = 4'd3,
      S_GAP_REF  = 4'd4,
      S_GAP_MRS  = 4'd5,
      S_READY    = 4'd6,
      S_ERROR    = 4'd7
   } state_t;

   state_t            state_q, state_d;
   logic [PW_W-1:0]   pwr_cnt_q, pwr_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [3:0]        ref_cnt_q, ref_cnt_d;
   logic [12:0]       mode_q, mode_d;
   logic [2:0]        err_code_q, err_code_d;

   logic [2:0]        cmd;
   logic              is_nop, is_pre, is_ref, is_lmr;
   logic              mode_ok;
   logic              eval_ref, eval_ready;
   logic              raise;
   logic [2:0]        raise_code;

   // Command decode and mode register legality (burst length, CAS latency, op mode)
   always_comb begin
      cmd     = {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
      is_nop  = DRAM_CS_N || (cmd == 3'b111);
      is_pre  = !DRAM_CS_N && (cmd == 3'b010);
      is_ref  = !DRAM_CS_N && (cmd == 3'b001);
      is_lmr  = !DRAM_CS_N && (cmd == 3'b000);
      mode_ok = ((DRAM_ADDR[2:0] <= 3'd3) || (DRAM_ADDR[2:0] == 3'd7))
                && ((DRAM_ADDR[6:4] == 3'd2) || (DRAM_ADDR[6:4] == 3'd3))
                && (DRAM_ADDR[8:7] == 2'b00);
   end

   // Next-state logic: sequence tracking, gap timing and first-error capture
   always_comb begin
      state_d    = state_q;
      pwr_cnt_d  = pwr_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      ref_cnt_d  = ref_cnt_q;
      mode_d     = mode_q;
      err_code_d = err_code_q;
      eval_ref   = 1'b0;
      eval_ready = 1'b0;
      raise      = 1'b0;
      raise_code = 3'd0;

      case (state_q)
         S_WAIT_PWR: begin
            if (!is_nop && (pwr_cnt_q < PW_W'(PWRUP_CYC))) begin
               raise      = 1'b1;
               raise_code = ERR_EARLY;
            end else begin
               if (DRAM_CKE && (pwr_cnt_q < PW_W'(PWRUP_CYC)))
                  pwr_cnt_d = pwr_cnt_q + PW_W'(1);
               if (pwr_cnt_d >= PW_W'(PWRUP_CYC))
                  state_d = S_WAIT_PRE;
            end
         end
         S_WAIT_PRE: begin
            if (!DRAM_CKE) begin
               raise      = 1'b1;
               raise_code = ERR_CKE;
            end else if (is_pre && DRAM_ADDR[10]) begin
               state_d   = S_GAP_PRE;
               gap_cnt_d = GAP_W'(TRP_CYC);
            end else if (!is_nop) begin
               raise      = 1'b1;
               raise_code = ERR_SEQ;
            end
         end
         S_GAP_PRE, S_GAP_REF: begin
            // A gap count of 1 means this edge is exactly the required distance away
            if (!DRAM_CKE) begin
               raise      = 1'b1;
               raise_code = ERR_CKE;
            end else if (gap_cnt_q > GAP_W'(1)) begin
               if (!is_nop) begin
                  raise      = 1'b1;
                  raise_code = ERR_TIMING;
               end else begin
                  gap_cnt_d = gap_cnt_q - GAP_W'(1);
               end
            end else begin
               eval_ref = 1'b1;
            end
         end
         S_WAIT_REF: begin
            if (!DRAM_CKE) begin
               raise      = 1'b1;
               raise_code = ERR_CKE;
            end else begin
               eval_ref = 1'b1;
            end
         end
         S_GAP_MRS: begin
            if (!DRAM_CKE) begin
               raise      = 1'b1;
               raise_code = ERR_CKE;
            end else if (gap_cnt_q > GAP_W'(1)) begin
               if (!is_nop) begin
                  raise      = 1'b1;
                  raise_code = ERR_TIMING;
               end else begin
                  gap_cnt_d = gap_cnt_q - GAP_W'(1);
               end
            end else begin
               state_d    = S_READY;
               eval_ready = 1'b1;
            end
         end
         S_READY: begin
            eval_ready = 1'b1;
         end
         default: begin
         end
      endcase

      // Refresh/mode-load phase, shared by WAIT_REF and the expired gap states
      if (eval_ref) begin
         state_d = S_WAIT_REF;
         if (is_ref) begin
            if (ref_cnt_q != 4'hF)
               ref_cnt_d = ref_cnt_q + 4'd1;
            state_d   = S_GAP_REF;
            gap_cnt_d = GAP_W'(TRFC_CYC);
         end else if (is_lmr) begin
            if ((ref_cnt_q < 4'(NUM_REF)) || (DRAM_BA != 2'b00)) begin
               raise      = 1'b1;
               raise_code = ERR_SEQ;
            end else if (!mode_ok) begin
               raise      = 1'b1;
               raise_code = ERR_MODE;
            end else begin
               mode_d    = DRAM_ADDR;
               state_d   = S_GAP_MRS;
               gap_cnt_d = GAP_W'(TMRD_CYC);
            end
         end else if (!is_nop) begin
            raise      = 1'b1;
            raise_code = ERR_SEQ;
         end
      end

      // Once ready, only a valid mode reload has any effect
      if (eval_ready && is_lmr && (DRAM_BA == 2'b00) && mode_ok)
         mode_d = DRAM_ADDR;

      if (raise) begin
         state_d    = S_ERROR;
         err_code_d = raise_code;
      end
   end

   // State and counter registers
   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         state_q    <= S_WAIT_PWR;
         pwr_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         ref_cnt_q  <= '0;
         mode_q     <= '0;
         err_code_q <= '0;
      end else begin
         state_q    <= state_d;
         pwr_cnt_q  <= pwr_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         ref_cnt_q  <= ref_cnt_d;
         mode_q     <= mode_d;
         err_code_q <= err_code_d;
      end
   end

   assign oready    = (state_q == S_READY);
   assign oerr      = (state_q == S_ERROR);
   assign oerr_code = err_code_q;
   assign omode_reg = mode_q;
   assign oref_cnt  = ref_cnt_q;
   assign ostate    = state_q;

endmodule

// File: tb/tb_sdram_init_checker.sv
// tb/tb_sdram_init_checker.sv - self-checking bench for sdram_init_checker
module tb_sdram_init_checker;

   localparam int PWR = 5000;

   localparam logic [3:0] S_WPWR  = 4'd0;
   localparam logic [3:0] S_WPRE  = 4'd1;
   localparam logic [3:0] S_GPRE  = 4'd2;
   localparam logic [3:0] S_GREF  = 4'd4;
   localparam logic [3:0] S_GMRS  = 4'd5;
   localparam logic [3:0] S_READY = 4'd6;
   localparam logic [3:0] S_ERR   = 4'd7;

   typedef struct packed {
      logic        ready;
      logic        err;
      logic [2:0]  code;
      logic [12:0] mode;
      logic [3:0]  refc;
      logic [3:0]  state;
   } snap_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cke, cs_n, ras_n, cas_n, we_n;
   logic [1:0]  ba;
   logic [12:0] addr;
   logic        oready, oerr;
   logic [2:0]  oerr_code;
   logic [12:0] omode_reg;
   logic [3:0]  oref_cnt, ostate;

   snap_t exp_q[$];
   snap_t e, g;
   int    checks = 0;
   int    errors = 0;

   sdram_init_checker dut (
      .iclk       (clk),
      .ireset     (rst_n),
      .DRAM_CKE   (cke),
      .DRAM_CS_N  (cs_n),
      .DRAM_RAS_N (ras_n),
      .DRAM_CAS_N (cas_n),
      .DRAM_WE_N  (we_n),
      .DRAM_BA    (ba),
      .DRAM_ADDR  (addr),
      .oready     (oready),
      .oerr       (oerr),
      .oerr_code  (oerr_code),
      .omode_reg  (omode_reg),
      .oref_cnt   (oref_cnt),
      .ostate     (ostate)
   );

   always #5 clk = ~clk;

   function automatic snap_t mk(input logic r, input logic er, input logic [2:0] c,
                                input logic [12:0] m, input logic [3:0] rc, input logic [3:0] st);
      snap_t s;
      s.ready = r; s.err = er; s.code = c; s.mode = m; s.refc = rc; s.state = st;
      return s;
   endfunction

   function automatic snap_t snap();
      snap_t s;
      s.ready = oready; s.err = oerr; s.code = oerr_code; s.mode = omode_reg;
      s.refc = oref_cnt; s.state = ostate;
      return s;
   endfunction

   task automatic drive(input logic c, input logic s, input logic [2:0] cmd,
                        input logic [1:0] b, input logic [12:0] a);
      cke = c; cs_n = s; {ras_n, cas_n, we_n} = cmd; ba = b; addr = a;
      @(posedge clk);
      #1;
   endtask

   // Alternates explicit NOP with deselect carrying a LOAD MODE code
   task automatic nop(input int n);
      for (int i = 0; i < n; i++)
         if (i % 2 == 1) drive(1'b1, 1'b1, 3'b000, 2'b00, 13'h0);
         else            drive(1'b1, 1'b0, 3'b111, 2'b00, 13'h0);
   endtask

   task automatic pre(input logic a10);
      drive(1'b1, 1'b0, 3'b010, 2'b00, {2'b00, a10, 10'h0});
   endtask

   task automatic ref_cmd();
      drive(1'b1, 1'b0, 3'b001, 2'b00, 13'h0);
   endtask

   task automatic lmr(input logic [1:0] b, input logic [12:0] a);
      drive(1'b1, 1'b0, 3'b000, b, a);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111; ba = 2'b00; addr = 13'h0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111; ba = 2'b00; addr = 13'h0;
      @(posedge clk);
      #1;
      exp_q.push_back(mk(0, 0, 3'd0, 13'h0, 4'd0, S_WPWR));
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_state got=%h exp=%h", g, e); end
      do_reset();
   endtask

   task automatic test_legal();
      do_reset();
      exp_q.push_back(mk(0, 0, 3'd0, 13'h0, 4'd0, S_WPRE));
      nop(PWR);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL legal_pwrup got=%h exp=%h", g, e); end
      exp_q.push_back(mk(0, 0, 3'd0, 13'h0, 4'd0, S_GPRE));
      pre(1'b1);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL legal_pre got=%h exp=%h", g, e); end
      nop(1);
      exp_q.push_back(mk(0, 0, 3'd0, 13'h0, 4'd1, S_GREF));
      ref_cmd();
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL legal_ref1 got=%h exp=%h", g, e); end
      nop(6);
      exp_q.push_back(mk(0, 0, 3'd0, 13'h0, 4'd2, S_GREF));
      ref_cmd();
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL legal_ref2 got=%h exp=%h", g, e); end
      nop(6);
      exp_q.push_back(mk(0, 0, 3'd0, 13'h020, 4'd2, S_GMRS));
      lmr(2'b00, 13'h020);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL legal_lmr got=%h exp=%h", g, e); end
      exp_q.push_back(mk(0, 0, 3'd0, 13'h020, 4'd2, S_GMRS));
      nop(1);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL legal_tmrd1 got=%h exp=%h", g, e); end
      exp_q.push_back(mk(1, 0, 3'd0, 13'h020, 4'd2, S_READY));
      nop(1);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL legal_ready got=%h exp=%h", g, e); end
      exp_q.push_back(mk(1, 0, 3'd0, 13'h030, 4'd2, S_READY));
      lmr(2'b00, 13'h030);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL ready_reload got=%h exp=%h", g, e); end
      exp_q.push_back(mk(1, 0, 3'd0, 13'h030, 4'd2, S_READY));
      lmr(2'b00, 13'h050);
      drive(1'b1, 1'b0, 3'b011, 2'b00, 13'h0);
      drive(1'b0, 1'b1, 3'b111, 2'b00, 13'h0);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL ready_ignore got=%h exp=%h", g, e); end
   endtask

   task automatic test_early();
      do_reset();
      nop(99);
      exp_q.push_back(mk(0, 1, 3'd1, 13'h0, 4'd0, S_ERR));
      pre(1'b1);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL early_100 got=%h exp=%h", g, e); end
      exp_q.push_back(mk(0, 1, 3'd1, 13'h0, 4'd0, S_ERR));
      nop(3);
      drive(1'b0, 1'b0, 3'b001, 2'b00, 13'h0);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL early_sticky got=%h exp=%h", g, e); end
      do_reset();
      nop(PWR - 1);
      exp_q.push_back(mk(0, 1, 3'd1, 13'h0, 4'd0, S_ERR));
      pre(1'b1);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL early_last got=%h exp=%h", g, e); end
   endtask

   task automatic test_cke_hold();
      do_reset();
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 3'b111, 2'b00, 13'h0);
      exp_q.push_back(mk(0, 0, 3'd0, 13'h0, 4'd0, S_WPWR));
      nop(PWR - 10);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL cke_hold_wait got=%h exp=%h", g, e); end
      exp_q.push_back(mk(0, 0, 3'd0, 13'h0, 4'd0, S_WPRE));
      nop(10);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL cke_hold_done got=%h exp=%h", g, e); end
   endtask

   task automatic test_timing();
      do_reset();
      nop(PWR);
      pre(1'b1);
      nop(1);
      ref_cmd();
      nop(2);
      exp_q.push_back(mk(0, 1, 3'd3, 13'h0, 4'd1, S_ERR));
      ref_cmd();
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL timing_trfc got=%h exp=%h", g, e); end
      do_reset();
      nop(PWR);
      pre(1'b1);
      exp_q.push_back(mk(0, 1, 3'd3, 13'h0, 4'd0, S_ERR));
      ref_cmd();
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL timing_trp got=%h exp=%h", g, e); end
   endtask

   task automatic test_seq();
      do_reset();
      nop(PWR);
      pre(1'b1);
      nop(1);
      ref_cmd();
      nop(6);
      exp_q.push_back(mk(0, 1, 3'd2, 13'h0, 4'd1, S_ERR));
      lmr(2'b00, 13'h020);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL seq_few_ref got=%h exp=%h", g, e); end
      do_reset();
      nop(PWR);
      exp_q.push_back(mk(0, 1, 3'd2, 13'h0, 4'd0, S_ERR));
      pre(1'b0);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL seq_pre_a10 got=%h exp=%h", g, e); end
   endtask

   task automatic test_mode();
      do_reset();
      nop(PWR);
      pre(1'b1);
      nop(1);
      ref_cmd();
      nop(6);
      ref_cmd();
      nop(6);
      exp_q.push_back(mk(0, 1, 3'd4, 13'h0, 4'd2, S_ERR));
      lmr(2'b00, 13'h050);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL mode_cl5 got=%h exp=%h", g, e); end
   endtask

   task automatic test_reset_cke();
      do_reset();
      nop(PWR);
      pre(1'b1);
      nop(1);
      ref_cmd();
      nop(2);
      #2 rst_n = 1'b0;
      #1;
      exp_q.push_back(mk(0, 0, 3'd0, 13'h0, 4'd0, S_WPWR));
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL midreset got=%h exp=%h", g, e); end
      do_reset();
      exp_q.push_back(mk(0, 0, 3'd0, 13'h0, 4'd0, S_WPRE));
      nop(PWR);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL rerun_pwrup got=%h exp=%h", g, e); end
      pre(1'b1);
      nop(1);
      ref_cmd();
      exp_q.push_back(mk(0, 1, 3'd5, 13'h0, 4'd1, S_ERR));
      drive(1'b0, 1'b0, 3'b111, 2'b00, 13'h0);
      e = exp_q.pop_front(); g = snap(); checks++;
      if (g !== e) begin errors++; $display("FAIL cke_drop got=%h exp=%h", g, e); end
   endtask

   initial begin
      test_reset();
      test_legal();
      test_early();
      test_cke_hold();
      test_timing();
      test_seq();
      test_mode();
      test_reset_cke();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
